// File: rtl/calc_muldiv.sv
// Iterative signed/unsigned multiply-divide, BITS_PER_CYCLE bits retired per RUN cycle.
// Latency: done pulses WIDTH/BITS_PER_CYCLE+1 edges after accept; start is ignored while busy.
`timescale 1ns/1ps
module calc_muldiv #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t state, state_nxt;

  logic               is_div;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   step;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               dz_now;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign accept   = (state == IDLE) && start;
  assign busy     = (state != IDLE);

  // Only signed ops record a sign; magnitude of the most-negative value is exact as unsigned.
  assign in_neg_a = op[0] & a[WIDTH-1];
  assign in_neg_b = op[0] & b[WIDTH-1];
  assign in_mag_a = in_neg_a ? -a : a;
  assign in_mag_b = in_neg_b ? -b : b;

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc layout: multiply = {partial product (W+1), multiplier}; divide = {remainder (W+1), quotient}.
  always_comb begin
    step = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        step = {step[2*WIDTH-1:0], 1'b0};
        if (step[2*WIDTH:WIDTH] >= {1'b0, mag_b}) begin
          step[2*WIDTH:WIDTH] = step[2*WIDTH:WIDTH] - {1'b0, mag_b};
          step[0]             = 1'b1;
        end
      end else begin
        if (step[0]) step[2*WIDTH:WIDTH] = step[2*WIDTH:WIDTH] + {1'b0, mag_a};
        step = step >> 1;
      end
    end
  end

  assign prod     = acc[2*WIDTH-1:0];
  assign prod_fix = (neg_a ^ neg_b) ? -prod : prod;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign dz_now   = is_div && (mag_b == '0);

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz_now) begin
        // Re-negating the magnitude restores the original dividend bit pattern.
        fix_lo = '1;
        fix_hi = neg_a ? -mag_a : mag_a;
      end else begin
        fix_lo = (neg_a ^ neg_b) ? -quo : quo;
        fix_hi = neg_a ? -rem : rem;
      end
    end
  end

  always_ff @(posedge clk0 or negedge reset) begin
    if (!reset) begin
      is_div      <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      acc         <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        is_div      <= op[1];
        neg_a       <= in_neg_a;
        neg_b       <= in_neg_b;
        mag_a       <= in_mag_a;
        mag_b       <= in_mag_b;
        cnt         <= '0;
        div_by_zero <= 1'b0;
        acc         <= op[1] ? {{(WIDTH+1){1'b0}}, in_mag_a} : {{(WIDTH+1){1'b0}}, in_mag_b};
      end
      if (state == RUN) begin
        acc <= step;
        cnt <= cnt + CW'(1);
      end
      if (state == FIX) begin
        hi          <= fix_hi;
        lo          <= fix_lo;
        div_by_zero <= dz_now;
        done        <= 1'b1;
      end
    end
  end

endmodule
